// File: rtl/mmult_accel_sdiv_seq.sv
// Iterative signed divider: radix-2 restoring division on magnitudes, one quotient
// bit per cycle, truncating (C-style) results, valid/ready on both sides.
module mmult_accel_sdiv_seq #(
    parameter int unsigned ID         = 1,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quot,
    output logic [DATA_WIDTH-1:0] rem,
    output logic                  div_by_zero
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    // Instance tag only; referenced so it is not flagged as unused.
    if (ID == 0) begin : g_id_zero
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [W-1:0]    dvd_q;      // |dividend|, shifted out MSB-first; becomes the quotient
    logic [W-1:0]    dvs_q;      // |divisor|
    logic [W-1:0]    racc_q;     // partial remainder magnitude
    logic            neg_quot_q;
    logic            neg_rem_q;
    logic            dz_q;
    logic [W-1:0]    quot_q;
    logic [W-1:0]    rem_q;
    logic            dbz_q;

    logic [W:0]      shifted;
    logic            step_ge;
    logic [W-1:0]    racc_step;
    logic [W-1:0]    dvd_step;
    logic [W-1:0]    abs_din0;
    logic [W-1:0]    abs_din1;

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

    // One restoring step and operand magnitudes (|MIN| wraps to 2^(W-1) unsigned).
    always_comb begin
        abs_din0  = din0[W-1] ? -din0 : din0;
        abs_din1  = din1[W-1] ? -din1 : din1;
        // racc_q < dvs_q <= 2^(W-1), so the shifted value never exceeds W bits of magnitude.
        shifted   = {racc_q, dvd_q[W-1]};
        step_ge   = (shifted >= {1'b0, dvs_q});
        racc_step = step_ge ? (shifted[W-1:0] - dvs_q) : shifted[W-1:0];
        dvd_step  = {dvd_q[W-2:0], step_ge};
    end

    // Control FSM and datapath; ce freezes everything, reset overrides ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            racc_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
        end else if (ce) begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        dvd_q      <= abs_din0;
                        dvs_q      <= abs_din1;
                        racc_q     <= '0;
                        neg_quot_q <= din0[W-1] ^ din1[W-1];
                        neg_rem_q  <= din0[W-1];
                        dz_q       <= (din1 == '0);
                        // Divide-by-zero skips the iterations: count 0 means finish next edge.
                        cnt_q      <= (din1 == '0) ? '0 : CntW'(W);
                        state_q    <= StCalc;
                    end
                end
                StCalc: begin
                    if (cnt_q != '0) begin
                        racc_q <= racc_step;
                        dvd_q  <= dvd_step;
                        cnt_q  <= cnt_q - 1'b1;
                    end else begin
                        // Sign fix-up; the only edge on which the visible results change.
                        if (dz_q) begin
                            quot_q <= '1;
                            rem_q  <= neg_rem_q ? -dvd_q : dvd_q;
                            dbz_q  <= 1'b1;
                        end else begin
                            quot_q <= neg_quot_q ? -dvd_q : dvd_q;
                            rem_q  <= neg_rem_q ? -racc_q : racc_q;
                            dbz_q  <= 1'b0;
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
